// File: rtl/benes_pkg.sv
// benes_pkg: shared sizes and types for the 16-port Benes permutation network
package benes_pkg;
    localparam int N            = 16;
    localparam int STAGES       = 7;
    localparam int SW_PER_STAGE = 8;
    localparam int DATA_W_DEF   = 4;
    typedef logic [DATA_W_DEF-1:0] lane_t;
    typedef logic [SW_PER_STAGE-1:0] stage_ctrl_t;
endpackage

// File: rtl/switch_2x2.sv
// switch_2x2: combinational two-lane exchange, sel=1 swaps the lanes
module switch_2x2 import benes_pkg::*; #(
    parameter int W = DATA_W_DEF
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         sel,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1
);
    assign out0 = sel ? in1 : in0;
    assign out1 = sel ? in0 : in1;
endmodule

// File: rtl/network_module.sv
// network_module: 16x16 Benes network, 7 stages of 2x2 switches with registered output lanes
module network_module import benes_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_port     [0:N-1],
    input  stage_ctrl_t       switch_set [0:STAGES-1],
    output logic [DATA_W-1:0] o_port     [0:N-1]
);
    // Even lines of a block go to its lower half, odd lines to its upper half.
    function automatic int unshuffle(input int b, input int j);
        int r;
        r = j % b;
        return j - r + ((r % 2 == 0) ? r / 2 : b / 2 + r / 2);
    endfunction

    // Lower half of a block interleaves onto even lines, upper half onto odd lines.
    function automatic int shuffle(input int b, input int j);
        int r;
        r = j % b;
        return j - r + ((r < b / 2) ? 2 * r : 2 * (r - b / 2) + 1);
    endfunction

    // Block size of the wiring that follows stage t: 16, 8, 4 going in, 4, 8, 16 coming out.
    function automatic int blk(input int t);
        return (t < 3) ? (N >> t) : (4 << (t - 3));
    endfunction

    // Line d after stage t is fed by line src_line(t, d) of that stage's output:
    // the source of an unshuffle is a shuffle of the destination and vice versa.
    function automatic int src_line(input int t, input int d);
        return (t < 3) ? shuffle(blk(t), d) : unshuffle(blk(t), d);
    endfunction

    logic [DATA_W-1:0] d_port [0:N-1];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [DATA_W-1:0] lv [0:N-1];
        logic [DATA_W-1:0] mv [0:N-1];
        for (genvar j = 0; j < N; j++) begin : g_line
            if (s == 0) begin : g_in
                assign lv[j] = i_port[j];
            end else begin : g_wire
                assign lv[j] = g_stage[s-1].mv[src_line(s - 1, j)];
            end
        end
        for (genvar k = 0; k < SW_PER_STAGE; k++) begin : g_sw
            switch_2x2 #(.W(DATA_W)) u_sw (
                .in0  (lv[2*k]),
                .in1  (lv[2*k+1]),
                .sel  (switch_set[s][k]),
                .out0 (mv[2*k]),
                .out1 (mv[2*k+1])
            );
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_out
        assign d_port[j] = g_stage[STAGES-1].mv[j];
    end

    // Output lane register: clears on reset, otherwise captures the last stage.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N; j++) o_port[j] <= rst ? '0 : d_port[j];
    end
endmodule

// File: tb/tb_network_module.sv
// tb_network_module: directed vector table plus routed random permutations for network_module
module tb_network_module;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i_port     [0:15];
    logic [7:0] switch_set [0:6];
    logic [3:0] o_port     [0:15];

    int checks = 0;
    int failures = 0;

    typedef struct {
        string           name;
        logic [63:0]     din;
        logic [6:0][7:0] ss;
        logic [63:0]     exp;
    } vec_t;

    vec_t vt [8];

    network_module #(.DATA_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_port     (i_port),
        .switch_set (switch_set),
        .o_port     (o_port)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] RAMP = 64'hFEDCBA9876543210;

    task automatic drive(input logic [63:0] din, input logic [6:0][7:0] ss);
        for (int i = 0; i < 16; i++) i_port[i] = din[4*i +: 4];
        for (int s = 0; s < 7; s++) switch_set[s] = ss[s];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] exp);
        logic [63:0] act;
        for (int j = 0; j < 16; j++) act[4*j +: 4] = o_port[j];
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Looping algorithm: p[j] is the input lane that must reach output j.
    task automatic route(input int p[16], output logic [6:0][7:0] ss);
        int d[16], nd[16], sr[16], sub[16];
        int n, i, i2;
        ss = '0;
        for (int j = 0; j < 16; j++) d[p[j]] = j;
        for (int l = 0; l < 3; l++) begin
            n = 16 >> l;
            for (int base = 0; base < 16; base += n) begin
                for (int k = 0; k < n; k++) begin
                    sr[d[base+k]] = k;
                    sub[k] = -1;
                end
                for (int a = 0; a < n / 2; a++) begin
                    if (sub[2*a] < 0) begin
                        i = 2 * a;
                        for (int g = 0; g < n && sub[i] < 0; g++) begin
                            sub[i] = 0;
                            i2 = sr[d[base+i] ^ 1];
                            sub[i2] = 1;
                            i = i2 ^ 1;
                        end
                    end
                end
                for (int a = 0; a < n / 2; a++) begin
                    ss[l][base/2 + a]   = (sub[2*a] == 1);
                    ss[6-l][base/2 + a] = (sub[sr[2*a]] == 1);
                end
                for (int k = 0; k < n; k++)
                    nd[base + ((sub[k] == 1) ? n / 2 : 0) + k / 2] = d[base+k] / 2;
            end
            d = nd;
        end
        for (int base = 0; base < 16; base += 2) ss[3][base/2] = (d[base] == 1);
    endtask

    initial begin
        logic [6:0][7:0] ss;
        logic [63:0] din, exp;
        int p[16];
        int t, r;

        vt[0] = '{"identity",  RAMP, 56'h0, RAMP};
        vt[1] = '{"all_cross", RAMP, {7{8'hFF}}, 64'h76543210FEDCBA98};
        vt[2] = '{"s0_sw0",    RAMP, 56'h01, 64'hFEDCBA9876543201};
        vt[3] = '{"s6_sw7",    RAMP, {8'h80, 48'h0}, 64'hEFDCBA9876543210};
        vt[4] = '{"s3_sw0",    RAMP, {24'h0, 8'h01, 24'h0}, 64'hFEDCBA9076543218};
        vt[5] = '{"s0_all",    RAMP, 56'hFF, 64'hEFCDAB8967452301};
        vt[6] = '{"s3_all",    RAMP, {24'h0, 8'hFF, 24'h0}, 64'h76543210FEDCBA98};
        vt[7] = '{"rev_ident", 64'h0123456789ABCDEF, 56'h0, 64'h0123456789ABCDEF};

        rst = 1'b1;
        drive(RAMP, 56'h0);
        tick();
        check("reset_edge1", 64'h0);
        tick();
        check("reset_edge2", 64'h0);
        rst = 1'b0;
        tick();
        check("reset_release", RAMP);

        for (int v = 0; v < 8; v++) begin
            drive(vt[v].din, vt[v].ss);
            tick();
            check(vt[v].name, vt[v].exp);
        end

        drive(RAMP, {7{8'hFF}});
        tick();
        drive(RAMP, 56'h0);
        check("latency_hold", 64'h76543210FEDCBA98);
        tick();
        check("latency_update", RAMP);

        for (int trial = 0; trial < 6; trial++) begin
            for (int j = 0; j < 16; j++) p[j] = j;
            for (int j = 15; j > 0; j--) begin
                r = int'($urandom_range(j, 0));
                t = p[j];
                p[j] = p[r];
                p[r] = t;
            end
            route(p, ss);
            for (int c = 0; c < 3; c++) begin
                din = {$urandom, $urandom};
                for (int j = 0; j < 16; j++) exp[4*j +: 4] = din[4*p[j] +: 4];
                drive(din, ss);
                tick();
                check($sformatf("perm%0d_cyc%0d", trial, c), exp);
                if (trial == 2 && c == 1) begin
                    rst = 1'b1;
                    tick();
                    check("perm_mid_reset", 64'h0);
                    rst = 1'b0;
                    tick();
                    check("perm_after_reset", exp);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
